// File: rtl/uart_rx18_pkg.sv
// Shared constants and state encoding for the 18-channel UART receiver.
package uart_rx18_pkg;

    localparam int CLKS_PER_BIT_2400 = 20833;
    localparam int FRAME_DATA_BITS   = 6;
    localparam int FRAMES_PER_WORD   = 3;
    localparam int GAP_BITS_DEFAULT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx18_frame.sv
// Single-frame decoder: line synchroniser, start/data/stop FSM and shift register.
module uart_rx18_frame
    import uart_rx18_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_2400,
    parameter int DATA_BITS    = FRAME_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_ok,
    output logic                 o_bad,
    output logic                 o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    rx_state_t            r_state, w_state_nxt;
    logic                 r_sync1, r_sync2;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [BW-1:0]        r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        o_ok        = 1'b0;
        o_bad       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (r_cnt == CNT_MID) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_END) begin
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = {r_sync2, r_shreg[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + BW'(1);
                    if (r_bit == BIT_LAST)
                        w_state_nxt = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_STOP: begin
                // Returning to IDLE at mid-stop lets back-to-back frames through.
                if (r_cnt == CNT_END) begin
                    w_cnt_nxt   = '0;
                    o_ok        = r_sync2;
                    o_bad       = ~r_sync2;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_data = r_shreg;
    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/uart_rx18.sv
// 18-channel UART receiver: assembles three 6-bit frames into one word,
// with frame-error discard and inter-frame gap timeout.
module uart_rx18
    import uart_rx18_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_2400,
    parameter int DATA_BITS    = FRAME_DATA_BITS,
    parameter int FRAMES       = FRAMES_PER_WORD,
    parameter int GAP_BITS     = GAP_BITS_DEFAULT
) (
    input  logic                        sys_clk,
    input  logic                        sys_reset,
    input  logic                        uart_rxd,
    output logic [DATA_BITS*FRAMES-1:0] rx_data,
    output logic                        rx_valid,
    output logic                        frame_err,
    output logic                        rx_busy
);

    localparam int IW       = $clog2(FRAMES);
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int GW       = $clog2(GAP_CLKS);
    localparam logic [IW-1:0] LAST_FRAME = IW'(FRAMES - 1);
    localparam logic [GW-1:0] GAP_END    = GW'(GAP_CLKS - 1);

    logic [DATA_BITS-1:0]                    w_frame_data;
    logic                                    w_frame_ok, w_frame_bad, w_frame_busy;
    logic [IW-1:0]                           r_frame_idx;
    logic [FRAMES-2:0][DATA_BITS-1:0]        r_slot;
    logic [GW-1:0]                           r_gap_cnt;
    logic [DATA_BITS*FRAMES-1:0]             r_rx_data;
    logic                                    r_rx_valid, r_frame_err;

    uart_rx18_frame #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS)
    ) u_frame (
        .i_clk  (sys_clk),
        .i_rst_n(sys_reset),
        .i_rxd  (uart_rxd),
        .o_data (w_frame_data),
        .o_ok   (w_frame_ok),
        .o_bad  (w_frame_bad),
        .o_busy (w_frame_busy)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_reset) begin
            r_frame_idx <= '0;
            r_slot      <= '0;
            r_gap_cnt   <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
                r_frame_idx <= '0;
            end else if (w_frame_ok) begin
                if (r_frame_idx == LAST_FRAME) begin
                    r_rx_data   <= {w_frame_data, r_slot};
                    r_rx_valid  <= 1'b1;
                    r_frame_idx <= '0;
                end else begin
                    for (int i = 0; i < FRAMES - 1; i++)
                        if (r_frame_idx == IW'(i))
                            r_slot[i] <= w_frame_data;
                    r_frame_idx <= r_frame_idx + IW'(1);
                end
            end
            // Stale slots need no clearing: they are rewritten before the next word uses them.
            if (!w_frame_busy && r_frame_idx != '0) begin
                if (r_gap_cnt == GAP_END) begin
                    r_gap_cnt   <= '0;
                    r_frame_idx <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + GW'(1);
                end
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign rx_busy   = w_frame_busy | (r_frame_idx != '0);

endmodule

// File: tb/tb_uart_rx18.sv
// Bench for uart_rx18: directed scenarios plus a randomized frame stream checked
// against a word-assembly model built from queues.
module tb_uart_rx18;

    localparam int CPB = 16;
    localparam int DB  = 6;
    localparam int NF  = 3;
    localparam int GAP = 4;

    logic        sys_clk   = 1'b0;
    logic        sys_reset = 1'b0;
    logic        uart_rxd  = 1'b1;
    logic [17:0] rx_data;
    logic        rx_valid, frame_err, rx_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] got_q[$];
    int          got_cyc_q[$];
    int          err_pulses = 0;
    int          both_cnt   = 0;
    int          long_valid = 0;
    logic        prev_valid = 1'b0;
    int          cyc        = 0;

    always #5 sys_clk = ~sys_clk;

    uart_rx18 #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .FRAMES      (NF),
        .GAP_BITS    (GAP)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (rx_valid) begin
            got_q.push_back(rx_data);
            got_cyc_q.push_back(cyc);
        end
        if (frame_err) err_pulses <= err_pulses + 1;
        if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
        if (rx_valid && prev_valid) long_valid <= long_valid + 1;
        prev_valid <= rx_valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] pack3(input logic [5:0] a, input logic [5:0] b,
                                          input logic [5:0] c);
        return (18'(c) << 12) | (18'(b) << 6) | 18'(a);
    endfunction

    task automatic idle(input int bits);
        uart_rxd = 1'b1;
        repeat (bits * CPB) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [5:0] d, input logic stop);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge sys_clk);
        for (int i = 0; i < DB; i++) begin
            uart_rxd = d[i];
            repeat (CPB) @(negedge sys_clk);
        end
        uart_rxd = stop;
        repeat (CPB) @(negedge sys_clk);
        uart_rxd = 1'b1;
    endtask

    task automatic test_reset();
        sys_reset = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_cmp++; if (rx_data !== 18'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        sys_reset = 1'b1;
        idle(2);
    endtask

    task automatic test_three_frames();
        int q0, e0;
        q0 = got_q.size(); e0 = err_pulses;
        send_frame(6'h15, 1'b1);
        send_frame(6'h2A, 1'b1);
        send_frame(6'h3F, 1'b1);
        idle(2);
        n_cmp++; if (got_q.size() - q0 != 1) begin n_bad++; $display("FAIL t1_count: got %0d want 1", got_q.size() - q0); end
        else begin
            n_cmp++; if (got_q[q0] !== 18'h3FA95) begin n_bad++; $display("FAIL t1_word: got %h want 3fa95", got_q[q0]); end
        end
        n_cmp++; if (rx_data !== 18'h3FA95) begin n_bad++; $display("FAIL t1_hold: got %h want 3fa95", rx_data); end
        n_cmp++; if (err_pulses != e0) begin n_bad++; $display("FAIL t1_ferr: got %0d want %0d", err_pulses, e0); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy: got %b want 0", rx_busy); end
    endtask

    task automatic test_glitch();
        int q0, e0;
        q0 = got_q.size(); e0 = err_pulses;
        uart_rxd = 1'b0;
        repeat (3) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL t2_busy_start: got %b want 1", rx_busy); end
        repeat (20) @(negedge sys_clk);
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL t2_busy_end: got %b want 0", rx_busy); end
        n_cmp++; if (got_q.size() != q0 || err_pulses != e0) begin
            n_bad++; $display("FAIL t2_pulses: got valid %0d ferr %0d want 0 0", got_q.size() - q0, err_pulses - e0);
        end
        idle(1);
    endtask

    task automatic test_frame_err();
        int q0, e0;
        q0 = got_q.size(); e0 = err_pulses;
        send_frame(6'h2A, 1'b1);
        send_frame(6'h15, 1'b0);
        idle(2);
        n_cmp++; if (err_pulses - e0 != 1) begin n_bad++; $display("FAIL t3_ferr: got %0d want 1", err_pulses - e0); end
        n_cmp++; if (got_q.size() != q0) begin n_bad++; $display("FAIL t3_novalid: got %0d want 0", got_q.size() - q0); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL t3_busy: got %b want 0", rx_busy); end
        send_frame(6'h01, 1'b1);
        send_frame(6'h02, 1'b1);
        send_frame(6'h03, 1'b1);
        idle(2);
        n_cmp++; if (got_q.size() - q0 != 1) begin n_bad++; $display("FAIL t3_count: got %0d want 1", got_q.size() - q0); end
        else begin
            n_cmp++; if (got_q[q0] !== 18'h03081) begin n_bad++; $display("FAIL t3_word: got %h want 03081", got_q[q0]); end
        end
    endtask

    task automatic test_gap();
        int q0;
        q0 = got_q.size();
        send_frame(6'h3F, 1'b1);
        send_frame(6'h3F, 1'b1);
        idle(5);
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL t4_busy: got %b want 0", rx_busy); end
        send_frame(6'h00, 1'b1);
        send_frame(6'h00, 1'b1);
        send_frame(6'h3F, 1'b1);
        idle(2);
        n_cmp++; if (got_q.size() - q0 != 1) begin n_bad++; $display("FAIL t4_count: got %0d want 1", got_q.size() - q0); end
        else begin
            n_cmp++; if (got_q[q0] !== 18'h3F000) begin n_bad++; $display("FAIL t4_word: got %h want 3f000", got_q[q0]); end
        end
    endtask

    task automatic test_reset_mid();
        int q0;
        logic [5:0] d1;
        d1 = 6'h15;
        send_frame(6'h0A, 1'b1);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            uart_rxd = d1[i];
            repeat (CPB) @(negedge sys_clk);
        end
        sys_reset = 1'b0;
        @(negedge sys_clk);
        sys_reset = 1'b1;
        uart_rxd  = 1'b1;
        n_cmp++; if (rx_data !== 18'h0) begin n_bad++; $display("FAIL t5_data: got %h want 0", rx_data); end
        n_cmp++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_bad++; $display("FAIL t5_flags: got busy %b valid %b ferr %b want 0 0 0", rx_busy, rx_valid, frame_err);
        end
        idle(3);
        q0 = got_q.size();
        send_frame(6'h11, 1'b1);
        send_frame(6'h22, 1'b1);
        send_frame(6'h33, 1'b1);
        idle(2);
        n_cmp++; if (got_q.size() - q0 != 1) begin n_bad++; $display("FAIL t5_count: got %0d want 1", got_q.size() - q0); end
        else begin
            n_cmp++; if (got_q[q0] !== pack3(6'h11, 6'h22, 6'h33)) begin
                n_bad++; $display("FAIL t5_word: got %h want %h", got_q[q0], pack3(6'h11, 6'h22, 6'h33));
            end
        end
    endtask

    task automatic test_loopback();
        int q0, c0, lat;
        logic [17:0] w;
        w  = 18'h25A5A;
        q0 = got_q.size();
        c0 = cyc;
        send_frame(w[5:0], 1'b1);
        send_frame(w[11:6], 1'b1);
        send_frame(w[17:12], 1'b1);
        idle(1);
        n_cmp++; if (got_q.size() - q0 != 1) begin n_bad++; $display("FAIL t6_count: got %0d want 1", got_q.size() - q0); end
        else begin
            lat = got_cyc_q[q0] - c0;
            n_cmp++; if (got_q[q0] !== w) begin n_bad++; $display("FAIL t6_word: got %h want %h", got_q[q0], w); end
            n_cmp++; if (lat > 24 * CPB || lat < 23 * CPB) begin
                n_bad++; $display("FAIL t6_latency: got %0d cycles want %0d..%0d", lat, 23 * CPB, 24 * CPB);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  part_q[$];
        logic [17:0] exp_q[$];
        int q0, e0, exp_err, gap, sel;
        logic [5:0] d;
        logic bad, prev_bad;
        q0 = got_q.size(); e0 = err_pulses; exp_err = 0; prev_bad = 1'b0;
        for (int k = 0; k < 36; k++) begin
            sel = $urandom_range(0, 19);
            gap = (sel < 3) ? $urandom_range(5, 6) : $urandom_range(0, 2);
            if (prev_bad && gap < 1) gap = 1;
            idle(gap);
            if (gap >= 5) part_q.delete();
            d   = 6'($urandom_range(0, 63));
            bad = ($urandom_range(0, 9) == 0);
            send_frame(d, ~bad);
            if (bad) begin
                exp_err++;
                part_q.delete();
            end else begin
                part_q.push_back(d);
                if (part_q.size() == 3) begin
                    exp_q.push_back(pack3(part_q[0], part_q[1], part_q[2]));
                    part_q.delete();
                end
            end
            prev_bad = bad;
        end
        idle(6);
        n_cmp++; if (got_q.size() - q0 != exp_q.size()) begin
            n_bad++; $display("FAIL rnd_count: got %0d want %0d", got_q.size() - q0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++; if (got_q[q0 + i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL rnd_word%0d: got %h want %h", i, got_q[q0 + i], exp_q[i]);
                end
            end
        end
        n_cmp++; if (err_pulses - e0 != exp_err) begin
            n_bad++; $display("FAIL rnd_ferr: got %0d want %0d", err_pulses - e0, exp_err);
        end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL rnd_busy: got %b want 0", rx_busy); end
    endtask

    task automatic test_pulse_rules();
        n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL both_pulses: got %0d want 0", both_cnt); end
        n_cmp++; if (long_valid != 0) begin n_bad++; $display("FAIL valid_width: got %0d long pulses want 0", long_valid); end
    endtask

    initial begin
        test_reset();
        test_three_frames();
        test_glitch();
        test_frame_err();
        test_gap();
        test_reset_mid();
        test_loopback();
        test_random();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
